// File: rtl/mips_pkg.sv
// mips_pkg: shared types and defaults for the multicycle MIPS memory interface
package mips_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE} memif_state_t;
    localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/mips_timeout_cnt.sv
// mips_timeout_cnt: saturating wait-cycle counter that flags the last allowed REQ cycle
module mips_timeout_cnt import mips_pkg::*; #(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clr ? '0 : (en && cnt_q != CW'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        cnt_q <= reset ? '0 : cnt_d;
    end
    assign expired = cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/mips_mem_if.sv
// mips_mem_if: bridges the multicycle control FSM's memread/memwrite to a req/ack external bus
module mips_mem_if import mips_pkg::*; #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memread,
    input  logic          memwrite,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          stall,
    output logic          err,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata
);
    memif_state_t  state_q, state_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic          bus_we_q, bus_we_d;
    logic          err_q, err_d;
    logic          clr, expired;
    logic          start;

    assign start = memread | memwrite;

    mips_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .en      (state_q == REQ && !bus_ack),
        .expired (expired)
    );

    // err_q is only ever set on the transition into DONE, so it doubles as the err pulse
    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = bus_we_q;
        err_d       = 1'b0;
        clr         = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                bus_addr_d  = addr;
                bus_wdata_d = wdata;
                bus_we_d    = memwrite;
                if (addr[1:0] != 2'b00) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = REQ;
                    clr     = 1'b1;
                end
            end
            REQ: if (bus_ack) begin
                state_d = DONE;
                rdata_d = bus_we_q ? rdata_q : bus_rdata;
            end else if (expired) begin
                state_d = DONE;
                err_d   = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rdata_q     <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            err_q       <= err_d;
        end
    end

    assign rdata     = rdata_q;
    assign err       = err_q;
    assign bus_req   = state_q == REQ;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign stall     = (state_q == REQ) | (state_q == IDLE & start);
endmodule

// File: tb/tb_mips_mem_if.sv
// tb_mips_mem_if: directed accesses with a scoreboard of expected completion results
module tb_mips_mem_if;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memread = 1'b0, memwrite = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        stall, err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          reqs;
    } exp_t;
    exp_t sb[$];
    logic [31:0] model_rdata = '0;

    mips_mem_if #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .memread   (memread),
        .memwrite  (memwrite),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ack_at: REQ cycle (1-based) in which bus_ack is driven; 0 means never
    task automatic access(input string nm, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rd_val);
        exp_t e;
        int   n;
        if (a[1:0] != 2'b00) begin
            e.err = 1'b1; e.reqs = 0;
        end else if (ack_at >= 1 && ack_at <= 4) begin
            e.err = 1'b0; e.reqs = ack_at;
            if (!wr) model_rdata = rd_val;
        end else begin
            e.err = 1'b1; e.reqs = 4;
        end
        e.rdata = model_rdata;
        sb.push_back(e);
        memread = rd; memwrite = wr; addr = a; wdata = wd; bus_rdata = rd_val;
        #1;
        chk({nm, "_c0_stall"}, 32'(stall), 32'd1);
        chk({nm, "_c0_req"}, 32'(bus_req), 32'd0);
        @(negedge clk);
        memread = 1'b0; memwrite = 1'b0; addr = 32'hFFFF_FFFC; wdata = 32'hBAD0_BAD0;
        n = 0;
        while (bus_req && n < 20) begin
            n++;
            chk({nm, "_req_stall"}, 32'(stall), 32'd1);
            chk({nm, "_bus_we"}, 32'(bus_we), 32'(wr));
            chk({nm, "_bus_addr"}, bus_addr, a);
            if (wr) chk({nm, "_bus_wdata"}, bus_wdata, wd);
            bus_ack = (n == ack_at);
            @(negedge clk);
            bus_ack = 1'b0;
        end
        e = sb.pop_front();
        chk({nm, "_req_cycles"}, 32'(n), 32'(e.reqs));
        chk({nm, "_done_err"}, 32'(err), 32'(e.err));
        chk({nm, "_done_rdata"}, rdata, e.rdata);
        chk({nm, "_done_stall"}, 32'(stall), 32'd0);
        @(negedge clk);
        chk({nm, "_idle_err"}, 32'(err), 32'd0);
        chk({nm, "_idle_req"}, 32'(bus_req), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);

        access("rd_fast", 1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hCAFE_F00D);
        access("wr_wait", 1'b0, 1'b1, 32'h40, 32'h1234_5678, 4, 32'hDEAD_BEEF);
        access("timeout", 1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h5555_AAAA);
        access("misalign", 1'b1, 1'b0, 32'h102, 32'h0, 1, 32'h6666_6666);
        access("rd_wr", 1'b1, 1'b1, 32'h8, 32'hA1A1_A1A1, 1, 32'h7777_7777);

        // a stray ack in IDLE must not load rdata or raise bus_req
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("stray_idle_rdata", rdata, model_rdata);
        chk("stray_idle_req", 32'(bus_req), 32'd0);

        access("rd_wait1", 1'b1, 1'b0, 32'h3C, 32'h0, 2, 32'hA5A5_5A5A);

        // reset during the second REQ cycle abandons the access
        memread = 1'b1; addr = 32'h300;
        @(negedge clk);
        memread = 1'b0;
        chk("rstreq_req1", 32'(bus_req), 32'd1);
        @(negedge clk);
        chk("rstreq_req2", 32'(bus_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_rdata = '0;
        chk("rstreq_req", 32'(bus_req), 32'd0);
        chk("rstreq_err", 32'(err), 32'd0);
        chk("rstreq_stall", 32'(stall), 32'd0);
        chk("rstreq_rdata", rdata, 32'd0);
        chk("rstreq_addr", bus_addr, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h7777_0000;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("late_ack_rdata", rdata, 32'd0);
        chk("late_ack_req", 32'(bus_req), 32'd0);
        chk("late_ack_err", 32'(err), 32'd0);

        access("post_rst_rd", 1'b1, 1'b0, 32'h4, 32'h0, 3, 32'h0BAD_CAFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
